// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream bundle for axis_packet_fifo.
//
// Carries one AXI-Stream link: tdata/tkeep/tlast/tvalid from source to sink,
// tready from sink to source.
//   master : the side that drives a stream (source)
//   slave  : the side that receives a stream (sink)
interface axis_packet_fifo_if #(
    parameter int unsigned AXIS_BYTES = 1
) ();
    logic [8*AXIS_BYTES-1:0] tdata;
    logic [AXIS_BYTES-1:0]   tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: single-clock store-and-forward AXI-Stream packet FIFO.
//
// A packet becomes visible to the read side only once its tlast beat has been
// written, so once the first beat of a packet leaves the FIFO the remaining
// beats follow on consecutive cycles (the downstream GMII MAC cannot tolerate
// holes inside a frame).
//
// Optional feature macro: AXIS_PACKET_FIFO_DROP_EN
//   defined   : input never back-pressures; a packet that finds the buffer full
//               is discarded up to its tlast and drop_o pulses once.
//   undefined : axis_i.tready = !full; packets longer than DEPTH beats must not
//               be sent (they would deadlock).
//
// Parameters:
//   AXIS_BYTES : data width in bytes on both streams
//   DEPTH      : storage depth in beats, power of two, >= 4
//
// Ports:
//   clk     : sole clock
//   sresetn : synchronous active-low reset
//   axis_i  : inbound stream (slave modport)
//   axis_o  : outbound stream (master modport)
//   drop_o  : one-cycle pulse per discarded packet (0 unless drop build)
module axis_packet_fifo #(
    parameter int unsigned AXIS_BYTES = 1,
    parameter int unsigned DEPTH      = 2048
) (
    input  logic               clk,
    input  logic               sresetn,
    axis_packet_fifo_if.slave  axis_i,
    axis_packet_fifo_if.master axis_o,
    output logic               drop_o
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned DataW  = 8 * AXIS_BYTES;
    localparam int unsigned EntryW = DataW + AXIS_BYTES + 1;

    // Pointers carry one extra bit so that full and empty are distinguishable.
    typedef logic [AddrW:0] ptr_t;
    localparam ptr_t DepthPtr = ptr_t'(DEPTH);
    localparam ptr_t PtrOne   = ptr_t'(1);

    typedef enum logic [1:0] {
        WrIdle,
        WrPkt,
        WrDrop
    } wr_state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [EntryW-1:0] mem_q [DEPTH];
    logic [EntryW-1:0] ram_q;

    ptr_t      wr_ptr_q;
    ptr_t      commit_ptr_q;
    ptr_t      rd_ptr_q;
    wr_state_e wr_state_q;

    logic full;
    logic in_hs;
    logic mem_we;
    logic rd_en;

    assign full  = (wr_ptr_q - rd_ptr_q) == DepthPtr;
    assign in_hs = axis_i.tvalid && axis_i.tready;

    // In the drop build a handshake can arrive while full or while discarding;
    // those beats must not reach the RAM.
    assign mem_we = in_hs && !full && (wr_state_q != WrDrop);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {axis_i.tdata, axis_i.tkeep, axis_i.tlast};
        end
        if (rd_en) begin
            ram_q <= mem_q[rd_ptr_q[AddrW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
`ifdef AXIS_PACKET_FIFO_DROP_EN
    logic drop_q;

    assign axis_i.tready = sresetn;
    assign drop_o        = drop_q;
`else
    assign axis_i.tready = sresetn && !full;
    assign drop_o        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            wr_state_q   <= WrIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
`ifdef AXIS_PACKET_FIFO_DROP_EN
            drop_q       <= 1'b0;
`endif
        end else begin
`ifdef AXIS_PACKET_FIFO_DROP_EN
            drop_q <= 1'b0;
`endif
            if (in_hs) begin
`ifdef AXIS_PACKET_FIFO_DROP_EN
                if (wr_state_q == WrDrop || full) begin
                    // Throw away the partial packet: rewinding to the last
                    // packet boundary never touches committed data.
                    wr_ptr_q <= commit_ptr_q;
                    if (axis_i.tlast) begin
                        drop_q     <= 1'b1;
                        wr_state_q <= WrIdle;
                    end else begin
                        wr_state_q <= WrDrop;
                    end
                end else
`endif
                if (axis_i.tlast) begin
                    wr_ptr_q     <= wr_ptr_q + PtrOne;
                    commit_ptr_q <= wr_ptr_q + PtrOne;
                    wr_state_q   <= WrIdle;
                end else begin
                    wr_ptr_q     <= wr_ptr_q + PtrOne;
                    wr_state_q   <= WrPkt;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: two-entry prefetch pipeline
    //
    // ram stage : RAM read register (ram_q / ram_vld_q)
    // out stage : output holding register (out_q / out_vld_q)
    //
    // The out stage, when valid, always holds the older beat. When it is
    // empty the ram stage is presented directly, which gives the two-cycle
    // commit-to-valid latency. A ram-stage beat that is presented but not
    // taken moves into the out stage unchanged, so the output stays stable
    // while the ram stage is refilled.
    // ------------------------------------------------------------------
    logic [EntryW-1:0] out_q;
    logic [EntryW-1:0] out_d;
    logic              out_vld_q;
    logic              out_vld_d;
    logic              ram_vld_q;
    logic              ram_vld_d;
    logic              pop;
    logic              pipe_full;

    assign pop       = axis_o.tvalid && axis_o.tready;
    // Ram stage cannot take new data only when both stages stay occupied.
    assign pipe_full = out_vld_q && ram_vld_q && !pop;
    assign rd_en     = (rd_ptr_q != commit_ptr_q) && !pipe_full;

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (out_vld_q) begin
            if (pop) begin
                out_d     = ram_q;
                out_vld_d = ram_vld_q;
            end
        end else if (ram_vld_q && !pop) begin
            out_d     = ram_q;
            out_vld_d = 1'b1;
        end
        ram_vld_d = rd_en || pipe_full;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            rd_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            ram_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            out_vld_q <= out_vld_d;
            ram_vld_q <= ram_vld_d;
            out_q     <= out_d;
        end
    end

    assign axis_o.tvalid = out_vld_q || ram_vld_q;
    assign {axis_o.tdata, axis_o.tkeep, axis_o.tlast} = out_vld_q ? out_q : ram_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo (DEPTH=64, AXIS_BYTES=1).
// Expected beats are queued when the input handshake completes; a monitor
// pops and compares on every output handshake. Works for both builds.
module tb_axis_packet_fifo;

    localparam int unsigned AB    = 1;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned DW    = 8 * AB;
`ifdef AXIS_PACKET_FIFO_DROP_EN
    localparam bit DROP_BUILD = 1'b1;
    localparam int EXP_DROPS  = 1;
`else
    localparam bit DROP_BUILD = 1'b0;
    localparam int EXP_DROPS  = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AB-1:0] keep;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic sresetn = 1'b0;
    logic drop_o;

    axis_packet_fifo_if #(.AXIS_BYTES(AB)) axis_i ();
    axis_packet_fifo_if #(.AXIS_BYTES(AB)) axis_o ();

    axis_packet_fifo #(
        .AXIS_BYTES(AB),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .sresetn(sresetn),
        .axis_i (axis_i),
        .axis_o (axis_o),
        .drop_o (drop_o)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int o_mode = 0;  // 0: stall, 1: always ready, 2: random ready
    int recv_cnt = 0;
    int sent_cnt = 0;
    int drop_cnt = 0;
    int last_hs_cyc = 0;
    int first_stall_beat = -1;
    bit saw_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output ready driver
    initial begin
        axis_o.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (o_mode)
                0:       axis_o.tready = 1'b0;
                1:       axis_o.tready = 1'b1;
                default: axis_o.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop, hold-while-stalled and no-gap-inside-packet
    beat_t prev;
    bit prev_stall = 1'b0;
    bit in_pkt = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (!sresetn) begin
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
        end else begin
            cur = {axis_o.tdata, axis_o.tkeep, axis_o.tlast};
            if (drop_o) drop_cnt++;
            if (prev_stall) begin
                check("hold_valid", 64'(axis_o.tvalid), 64'(1));
                check("hold_beat", 64'(cur), 64'(prev));
            end else if (in_pkt) begin
                check("no_gap_in_packet", 64'(axis_o.tvalid), 64'(1));
            end
            if (axis_o.tvalid && axis_o.tready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                recv_cnt++;
                in_pkt = !axis_o.tlast;
            end
            prev_stall = axis_o.tvalid && !axis_o.tready;
            prev       = cur;
        end
    end

    // Send the first nsend beats of a len-beat packet.
    task automatic send_pkt(input int len, input int nsend, input bit push, input bit incr,
                            input bit gaps);
        beat_t b;
        bit acc;
        int w;
        for (int i = 0; i < nsend; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                axis_i.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            b.data = incr ? DW'(i) : DW'($urandom);
            b.keep = incr ? {AB{1'b1}} : AB'($urandom);
            b.last = (i == len - 1);
            axis_i.tdata  = b.data;
            axis_i.tkeep  = b.keep;
            axis_i.tlast  = b.last;
            axis_i.tvalid = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                acc = axis_i.tready;
                if (!acc && !saw_stall) begin
                    saw_stall        = 1'b1;
                    first_stall_beat = i;
                end
                if (acc && b.last) last_hs_cyc = cyc;
                @(posedge clk);
                #1;
                w++;
            end while (!acc && w < 3000);
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no tready for beat %0d, expected acceptance", i);
                axis_i.tvalid = 1'b0;
                return;
            end
            if (push) begin
                sb.push_back(b);
                sent_cnt++;
            end
        end
        axis_i.tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        o_mode = 1;
        while (sb.size() != 0 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        repeat (10) @(posedge clk);
        #1;
        check(name, 64'(sb.size()), 64'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rise;
        int len;
        axis_i.tvalid = 1'b0;
        axis_i.tdata  = '0;
        axis_i.tkeep  = '0;
        axis_i.tlast  = 1'b0;

        // Reset state
        idle(3);
        @(negedge clk);
        check("rst_tvalid", 64'(axis_o.tvalid), 64'(0));
        check("rst_tready", 64'(axis_i.tready), 64'(0));
        check("rst_drop", 64'(drop_o), 64'(0));
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        @(negedge clk);
        check("tready_after_rst", 64'(axis_i.tready), 64'(1));
        check("tvalid_after_rst", 64'(axis_o.tvalid), 64'(0));

        // Single 64-beat packet 0x00..0x3F, output always ready
        o_mode = 1;
        idle(3);
        send_pkt(64, 64, 1'b1, 1'b1, 1'b0);
        rise = -1;
        for (int k = 0; k < 10 && rise < 0; k++) begin
            @(negedge clk);
            if (axis_o.tvalid) rise = cyc;
        end
        check("first_valid_latency", 64'(rise), 64'(last_hs_cyc + 2));
        drain("drain_single");

        // Back-to-back packets, random output ready
        o_mode = 2;
        send_pkt(60, 60, 1'b1, 1'b0, 1'b0);
        send_pkt(1, 1, 1'b1, 1'b0, 1'b0);
        send_pkt(40, 40, 1'b1, 1'b0, 1'b0);
        drain("drain_b2b_random");

        // Same shape with output continuously ready
        send_pkt(60, 60, 1'b1, 1'b0, 1'b0);
        send_pkt(1, 1, 1'b1, 1'b0, 1'b0);
        send_pkt(40, 40, 1'b1, 1'b0, 1'b0);
        drain("drain_b2b_ready");

        // Overflow: output stalled, two 40-beat packets
        o_mode = 0;
        idle(4);
        saw_stall = 1'b0;
        send_pkt(40, 40, 1'b1, 1'b0, 1'b0);
        saw_stall = 1'b0;
        first_stall_beat = -1;
        fork
            send_pkt(40, 40, !DROP_BUILD, 1'b0, 1'b0);
            begin
                idle(150);
                o_mode = 1;
            end
        join
        drain("drain_overflow");
`ifdef AXIS_PACKET_FIFO_DROP_EN
        check("drop_tready_never_low", 64'(saw_stall), 64'(0));
        check("drop_pulse_count", 64'(drop_cnt), 64'(1));
`else
        check("bp_stall_seen", 64'(saw_stall), 64'(1));
        // The first packet's two oldest beats already sit in the read
        // pipeline, so only 38 RAM slots are held when the second starts.
        check("bp_beats_before_stall", 64'(first_stall_beat), 64'(DEPTH - 40 + 2));
`endif

        // Pointer wrap: 100 packets of 7 beats, output always ready
        for (int p = 0; p < 100; p++) send_pkt(7, 7, 1'b1, 1'b0, 1'b0);
        drain("drain_wrap");

        // Random lengths, random input gaps, random output ready
        o_mode = 2;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, DEPTH);
`ifdef AXIS_PACKET_FIFO_DROP_EN
            begin
                int w = 0;
                while (sent_cnt - recv_cnt + len > int'(DEPTH) && w < 5000) begin
                    @(posedge clk);
                    w++;
                end
                #1;
            end
`endif
            send_pkt(len, len, 1'b1, 1'b0, 1'b1);
        end
        drain("drain_random");

        // Reset mid-write and mid-read
        o_mode = 0;
        idle(2);
        send_pkt(8, 8, 1'b1, 1'b0, 1'b0);
        o_mode = 2;
        send_pkt(10, 5, 1'b0, 1'b0, 1'b0);
        sresetn = 1'b0;
        sb.delete();
        sent_cnt = 0;
        recv_cnt = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tvalid_after_mid_rst", 64'(axis_o.tvalid), 64'(0));
        check("tready_in_mid_rst", 64'(axis_i.tready), 64'(0));
        @(posedge clk);
        #1;
        sresetn = 1'b1;
        o_mode = 1;
        idle(2);
        send_pkt(3, 3, 1'b1, 1'b0, 1'b0);
        drain("drain_after_rst");
        check("residue_beats", 64'(recv_cnt), 64'(3));

        check("drop_total", 64'(drop_cnt), 64'(EXP_DROPS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
